cios_reduce_row: RTL and testbench



---
 rtl/cios_reduce_row_if.sv | 34 +++
 rtl/cios_reduce_row.sv | 137 +++++++++++++
 tb/tb_cios_reduce_row.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cios_reduce_row_if.sv
// Handshake and data bundle for one CIOS reduction row.
interface cios_reduce_row_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NWORDS = 8
);
    localparam int unsigned IDX_W = $clog2(NWORDS + 1);

    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] m_in;
    logic [WIDTH-1:0] carry_in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] t_word;
    logic [WIDTH-1:0] p_word;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_word;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             busy;

    // Producer/consumer side (drives requests, takes results)
    modport master (
        output start_valid, m_in, carry_in, in_valid, t_word, p_word, out_ready,
        input  start_ready, in_ready, out_valid, out_word, out_idx, out_last, busy
    );

    // Reduction row side
    modport slave (
        input  start_valid, m_in, carry_in, in_valid, t_word, p_word, out_ready,
        output start_ready, in_ready, out_valid, out_word, out_idx, out_last, busy
    );
endinterface

// File: rtl/cios_reduce_row.sv
// One row of CIOS Montgomery reduction: T' = (T + m*p) >> WIDTH, word-serial.
// Word 0 is handled upstream; this block consumes T[1..NWORDS+1] and p[1..NWORDS-1]
// and emits T'[0..NWORDS] through a single-entry registered output stage.
module cios_reduce_row #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NWORDS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cios_reduce_row_if.slave      bus
);
    localparam int unsigned IDX_W = $clog2(NWORDS + 1);
    localparam int unsigned J_W   = $clog2(NWORDS + 2);
    localparam int unsigned DW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [J_W-1:0]   j_q, j_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_word_q, out_word_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;
    logic             busy_q, busy_d;
    logic             start_ready_q, start_ready_d;

    logic             in_ready_c;
    logic             accept_c;
    logic             is_last_c;
    logic [WIDTH-1:0] p_eff_c;
    logic [DW-1:0]    sum_c;

    // Accept a new pair only while running and the output slot is free or draining now
    assign in_ready_c = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
    assign accept_c   = in_ready_c && bus.in_valid;
    assign is_last_c  = (j_q == J_W'(NWORDS + 1));

    // Upper words (j >= NWORDS) only fold the carry in, so the modulus term is zeroed.
    // With p forced to 0 the same 2*WIDTH adder yields the single carry bit for j = NWORDS
    // and the truncated top word for j = NWORDS+1.
    assign p_eff_c = (j_q < J_W'(NWORDS)) ? bus.p_word : '0;
    assign sum_c   = DW'(bus.t_word) + (DW'(m_q) * DW'(p_eff_c)) + DW'(c_q);

    // Next-state, datapath and output-stage update
    always_comb begin
        state_d       = state_q;
        m_d           = m_q;
        c_d           = c_q;
        j_d           = j_q;
        out_valid_d   = out_valid_q;
        out_word_d    = out_word_q;
        out_idx_d     = out_idx_q;
        out_last_d    = out_last_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_valid) begin
                    m_d     = bus.m_in;
                    c_d     = bus.carry_in;
                    j_d     = J_W'(1);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept_c) begin
                    c_d = sum_c[DW-1:WIDTH];
                    j_d = j_q + J_W'(1);
                    if (is_last_c) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && bus.out_ready && out_last_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept_c) begin
            out_valid_d = 1'b1;
            out_word_d  = sum_c[WIDTH-1:0];
            out_idx_d   = IDX_W'(j_q - J_W'(1));
            out_last_d  = is_last_c;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        busy_d        = (state_d != ST_IDLE);
        start_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            m_q           <= '0;
            c_q           <= '0;
            j_q           <= '0;
            out_valid_q   <= 1'b0;
            out_word_q    <= '0;
            out_idx_q     <= '0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            m_q           <= m_d;
            c_q           <= c_d;
            j_q           <= j_d;
            out_valid_q   <= out_valid_d;
            out_word_q    <= out_word_d;
            out_idx_q     <= out_idx_d;
            out_last_q    <= out_last_d;
            busy_q        <= busy_d;
            start_ready_q <= start_ready_d;
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_word    = out_word_q;
    assign bus.out_idx     = out_idx_q;
    assign bus.out_last    = out_last_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_cios_reduce_row.sv
// Scoreboard bench for cios_reduce_row (WIDTH=8, NWORDS=4).
// Expected rows come from whole-row integer arithmetic: T' = (T_hi + m*p_hi + C) mod 2^(W*(S+1)).
module tb_cios_reduce_row;
    localparam int unsigned W     = 8;
    localparam int unsigned S     = 4;
    localparam int unsigned IDX_W = $clog2(S + 1);

    typedef logic [W-1:0] row_t [S+1];
    typedef struct {
        logic [W-1:0]     word;
        logic [IDX_W-1:0] idx;
        logic             last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bp_en = 1'b0;
    logic bp_rand = 1'b1;
    logic or_force = 1'b1;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    cios_reduce_row_if #(.WIDTH(W), .NWORDS(S)) bus ();

    cios_reduce_row #(.WIDTH(W), .NWORDS(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.out_ready = bp_en ? bp_rand : or_force;

    // Random downstream stall pattern
    initial begin
        forever begin
            @(negedge clk);
            bp_rand = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: one wide addition over the whole row, then split into words
    task automatic push_row(input logic [W-1:0] m, input logic [W-1:0] c, input row_t t, input row_t p);
        longint unsigned r  = 0;
        longint unsigned pp = 0;
        exp_t e;
        for (int k = 0; k <= int'(S); k++) r += 64'(t[k]) << (W * k);
        for (int k = 0; k < int'(S) - 1; k++) pp += 64'(p[k]) << (W * k);
        r = r + 64'(m) * pp + 64'(c);
        r = r & ((64'(1) << (W * (S + 1))) - 64'(1));
        for (int k = 0; k <= int'(S); k++) begin
            e.word = W'(r >> (W * k));
            e.idx  = IDX_W'(k);
            e.last = (k == int'(S));
            exp_q.push_back(e);
        end
    endtask

    task automatic start_row(input logic [W-1:0] m, input logic [W-1:0] c);
        logic ok = 1'b0;
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.m_in        = m;
        bus.carry_in    = c;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus.start_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("start_handshake", 64'(ok), 64'(1));
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] t, input logic [W-1:0] p, input int gap);
        logic ok = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.t_word   = t;
        bus.p_word   = p;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("in_handshake", 64'(ok), 64'(1));
    endtask

    task automatic wait_idle();
        logic done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && !bus.busy) begin
                done = 1'b1;
                break;
            end
        end
        check("row_drain", 64'(done), 64'(1));
    endtask

    task automatic run_row(input logic [W-1:0] m, input logic [W-1:0] c, input row_t t, input row_t p,
                           input bit gaps);
        push_row(m, c, t, p);
        start_row(m, c);
        for (int k = 0; k <= int'(S); k++) send(t[k], p[k], gaps ? int'($urandom_range(0, 2)) : 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_idle();
    endtask

    // Monitor: pops the scoreboard on every output handshake, checks hold-while-stalled
    initial begin
        exp_t e;
        logic             hold = 1'b0;
        logic [W-1:0]     h_word = '0;
        logic [IDX_W-1:0] h_idx = '0;
        logic             h_last = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                check("hold_valid", 64'(bus.out_valid), 64'(1));
                check("hold_word", 64'(bus.out_word), 64'(h_word));
                check("hold_idx", 64'(bus.out_idx), 64'(h_idx));
                check("hold_last", 64'(bus.out_last), 64'(h_last));
            end
            if (bus.out_valid && !bus.out_ready) check("stall_in_ready", 64'(bus.in_ready), 64'(0));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got word 0x%0h idx %0d with empty scoreboard",
                             bus.out_word, bus.out_idx);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", 64'(bus.out_word), 64'(e.word));
                    check("out_idx", 64'(bus.out_idx), 64'(e.idx));
                    check("out_last", 64'(bus.out_last), 64'(e.last));
                end
            end
            hold   = bus.out_valid && !bus.out_ready;
            h_word = bus.out_word;
            h_idx  = bus.out_idx;
            h_last = bus.out_last;
        end
    end

    // Main sequence
    initial begin
        row_t tt;
        row_t pp;
        logic [W-1:0] mm;
        logic [W-1:0] cc;

        bus.start_valid = 1'b0;
        bus.m_in        = '0;
        bus.carry_in    = '0;
        bus.in_valid    = 1'b0;
        bus.t_word      = '0;
        bus.p_word      = '0;

        // Reset values
        repeat (3) @(negedge clk);
        #2;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_word", 64'(bus.out_word), 64'(0));
        check("rst_out_idx", 64'(bus.out_idx), 64'(0));
        check("rst_out_last", 64'(bus.out_last), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_start_ready", 64'(bus.start_ready), 64'(1));
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Max-carry word
        tt = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        pp = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        run_row(8'hFF, 8'hFE, tt, pp, 1'b0);

        // Carry of 1 propagating into the final two words
        tt = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        pp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_row(8'h00, 8'h01, tt, pp, 1'b0);
        check("idle_start_ready", 64'(bus.start_ready), 64'(1));
        check("idle_busy", 64'(bus.busy), 64'(0));

        // Streaming row: five back-to-back outputs, busy drops right after the last
        tt = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        pp = '{8'hC3, 8'h5A, 8'hE7, 8'h11, 8'h22};
        fork
            run_row(8'h6B, 8'hA1, tt, pp, 1'b0);
            begin
                logic seen = 1'b0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    #3;
                    if (bus.out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check("stream_first_valid", 64'(seen), 64'(1));
                for (int k = 0; k <= int'(S); k++) begin
                    check("stream_valid", 64'(bus.out_valid), 64'(1));
                    check("stream_idx", 64'(bus.out_idx), 64'(k));
                    @(negedge clk);
                    #3;
                end
                check("stream_busy_after_last", 64'(bus.busy), 64'(0));
                check("stream_start_ready_after_last", 64'(bus.start_ready), 64'(1));
            end
        join

        // Backpressure: three stalled cycles with input pending
        tt = '{8'hA5, 8'h5A, 8'hF0, 8'h0F, 8'h33};
        pp = '{8'h81, 8'h7E, 8'h99, 8'h00, 8'h00};
        fork
            run_row(8'hD2, 8'h47, tt, pp, 1'b0);
            begin
                repeat (3) @(negedge clk);
                or_force = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    #3;
                    check("bp_out_valid", 64'(bus.out_valid), 64'(1));
                    check("bp_in_ready", 64'(bus.in_ready), 64'(0));
                    @(negedge clk);
                end
                or_force = 1'b1;
            end
        join

        // Start request during RUN must not disturb the row
        tt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        pp = '{8'hF1, 8'hE2, 8'hD3, 8'h00, 8'h00};
        fork
            run_row(8'h35, 8'h09, tt, pp, 1'b0);
            begin
                repeat (4) @(negedge clk);
                bus.start_valid = 1'b1;
                bus.m_in        = 8'hAA;
                bus.carry_in    = 8'h55;
                #3;
                check("run_start_ready", 64'(bus.start_ready), 64'(0));
                repeat (2) @(negedge clk);
                bus.start_valid = 1'b0;
            end
        join

        // Reset in the middle of a row, with word j=2 pending
        or_force = 1'b0;
        start_row(8'h12, 8'h34);
        send(8'h77, 8'h88, 0);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_out_word", 64'(bus.out_word), 64'(0));
        check("mid_rst_out_idx", 64'(bus.out_idx), 64'(0));
        check("mid_rst_out_last", 64'(bus.out_last), 64'(0));
        check("mid_rst_busy", 64'(bus.busy), 64'(0));
        check("mid_rst_start_ready", 64'(bus.start_ready), 64'(1));
        exp_q.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        or_force = 1'b1;

        // Clean row after reset (stale m and C must not leak in)
        tt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        pp = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        run_row(8'h03, 8'h00, tt, pp, 1'b0);

        // Randomized rows with input gaps and random downstream stalls
        bp_en = 1'b1;
        for (int r = 0; r < 25; r++) begin
            mm = W'($urandom);
            cc = W'($urandom);
            for (int k = 0; k <= int'(S); k++) begin
                tt[k] = W'($urandom);
                pp[k] = W'($urandom);
            end
            run_row(mm, cc, tt, pp, 1'b1);
        end
        bp_en = 1'b0;

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
